// File: rtl/cpu_cu_pkg.sv
// Shared types for the CPU control unit: state encodings, instruction classes,
// branch-condition codes and the packed EU control word.
package cpu_cu_pkg;

    localparam int unsigned STATE_W       = 4;
    localparam int unsigned CLASS_LSB_DEF = 9;
    localparam int unsigned COND_LSB      = 6;
    localparam int unsigned IR_W          = 16;
    localparam int unsigned PSR_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = STATE_W'(0),
        S_FETCH  = STATE_W'(1),
        S_DECODE = STATE_W'(2),
        S_ALU    = STATE_W'(3),
        S_LOAD   = STATE_W'(4),
        S_STORE  = STATE_W'(5),
        S_JUMP   = STATE_W'(6),
        S_BRANCH = STATE_W'(7),
        S_HALT   = STATE_W'(8)
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'b000,
        CLS_LOAD   = 3'b001,
        CLS_STORE  = 3'b010,
        CLS_JUMP   = 3'b011,
        CLS_BRANCH = 3'b100,
        CLS_ILL5   = 3'b101,
        CLS_ILL6   = 3'b110,
        CLS_HALT   = 3'b111
    } cls_e;

    typedef enum logic [2:0] {
        BC_ALWAYS = 3'b000,
        BC_Z      = 3'b001,
        BC_NZ     = 3'b010,
        BC_C      = 3'b011,
        BC_NC     = 3'b100,
        BC_N      = 3'b101,
        BC_NN     = 3'b110,
        BC_NEVER  = 3'b111
    } bcond_e;

    // psr bit positions: {C,N,Z}
    localparam int unsigned PSR_C = 2;
    localparam int unsigned PSR_N = 1;
    localparam int unsigned PSR_Z = 0;

    typedef struct packed {
        logic w_en;
        logic s_sel;
        logic pc_ld;
        logic pc_inc;
        logic ir_ld;
        logic adr_sel;
        logic mr_en;
        logic mw_en;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/cpu_cu_if.sv
// Control-unit <-> execution-unit bus: IR and flags in, control word and psr out.
interface cpu_cu_if;
    import cpu_cu_pkg::*;

    logic [IR_W-1:0]  ir;
    logic             c;
    logic             n;
    logic             z;
    logic             w_en;
    logic             s_sel;
    logic             pc_ld;
    logic             pc_inc;
    logic             ir_ld;
    logic             adr_sel;
    logic             mr_en;
    logic             mw_en;
    logic [PSR_W-1:0] psr;
    logic             halted;

    modport master (
        input  ir, c, n, z,
        output w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, mr_en, mw_en, psr, halted
    );

    modport slave (
        output ir, c, n, z,
        input  w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, mr_en, mw_en, psr, halted
    );

endinterface

// File: rtl/cpu_cu_bcond.sv
// Branch-condition evaluator: decides a BRANCH from the IR condition field and latched psr.
module cpu_cu_bcond
    import cpu_cu_pkg::*;
(
    input  logic [2:0]       cond,
    input  logic [PSR_W-1:0] psr,
    output logic             taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (bcond_e'(cond))
            BC_ALWAYS: taken_c = 1'b1;
            BC_Z:      taken_c = psr[PSR_Z];
            BC_NZ:     taken_c = ~psr[PSR_Z];
            BC_C:      taken_c = psr[PSR_C];
            BC_NC:     taken_c = ~psr[PSR_C];
            BC_N:      taken_c = psr[PSR_N];
            BC_NN:     taken_c = ~psr[PSR_N];
            BC_NEVER:  taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// CPU control unit: Moore FSM sequencing fetch/decode/execute and driving the EU control word.
// Optional feature macro: CPU_CU_ILLEGAL_TRAP_EN (classes 101/110 halt instead of acting as NOPs).
module cpu_cu
    import cpu_cu_pkg::*;
#(
    parameter int unsigned CLASS_LSB = CLASS_LSB_DEF
) (
    input  logic     clk,
    input  logic     reset,
    cpu_cu_if.master bus
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q,  ctrl_d;
    logic [PSR_W-1:0] psr_q,   psr_d;
    logic             taken_c;
    cls_e             cls_c;
    logic             unused_ir_c;

    assign cls_c       = cls_e'(bus.ir[CLASS_LSB +: 3]);
    assign unused_ir_c = ^{bus.ir[IR_W-1:12], bus.ir[COND_LSB-1:0]};

    cpu_cu_bcond u_bcond (
        .cond    (bus.ir[COND_LSB +: 3]),
        .psr     (psr_q),
        .taken_c (taken_c)
    );

    // Next state, then the control word is a decode of that next state so it registers alongside it.
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        psr_d   = psr_q;

        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (cls_c)
                    CLS_ALU:    state_d = S_ALU;
                    CLS_LOAD:   state_d = S_LOAD;
                    CLS_STORE:  state_d = S_STORE;
                    CLS_JUMP:   state_d = S_JUMP;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_HALT:   state_d = S_HALT;
`ifdef CPU_CU_ILLEGAL_TRAP_EN
                    CLS_ILL5, CLS_ILL6: state_d = S_HALT;
`else
                    CLS_ILL5, CLS_ILL6: state_d = S_FETCH;
`endif
                endcase
            end
            S_ALU, S_LOAD, S_STORE, S_JUMP, S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RESET;
        endcase

        // Branch decision is taken while IR and psr are stable in DECODE.
        case (state_d)
            S_FETCH: begin
                ctrl_d.mr_en  = 1'b1;
                ctrl_d.ir_ld  = 1'b1;
                ctrl_d.pc_inc = 1'b1;
            end
            S_ALU:   ctrl_d.w_en = 1'b1;
            S_LOAD: begin
                ctrl_d.adr_sel = 1'b1;
                ctrl_d.mr_en   = 1'b1;
                ctrl_d.s_sel   = 1'b1;
                ctrl_d.w_en    = 1'b1;
            end
            S_STORE: begin
                ctrl_d.adr_sel = 1'b1;
                ctrl_d.mw_en   = 1'b1;
            end
            S_JUMP:   ctrl_d.pc_ld  = 1'b1;
            S_BRANCH: ctrl_d.pc_ld  = taken_c;
            S_HALT:   ctrl_d.halted = 1'b1;
            default:  ctrl_d = '0;
        endcase

        if (state_q == S_ALU) begin
            psr_d = {bus.c, bus.n, bus.z};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
            psr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            psr_q   <= psr_d;
        end
    end

    assign bus.w_en    = ctrl_q.w_en;
    assign bus.s_sel   = ctrl_q.s_sel;
    assign bus.pc_ld   = ctrl_q.pc_ld;
    assign bus.pc_inc  = ctrl_q.pc_inc;
    assign bus.ir_ld   = ctrl_q.ir_ld;
    assign bus.adr_sel = ctrl_q.adr_sel;
    assign bus.mr_en   = ctrl_q.mr_en;
    assign bus.mw_en   = ctrl_q.mw_en;
    assign bus.halted  = ctrl_q.halted;
    assign bus.psr     = psr_q;

endmodule

// File: tb/tb_cpu_cu.sv
// Self-checking bench for cpu_cu: directed scenarios plus randomized instruction streams,
// checked every cycle against an instruction-level behavioural model.
module tb_cpu_cu;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cpu_cu_if bus ();

    cpu_cu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Output vector: {halted, w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, mr_en, mw_en}
    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_FETCH = 9'b000011010;
    localparam logic [8:0] O_ALU   = 9'b010000000;
    localparam logic [8:0] O_LOAD  = 9'b011000110;
    localparam logic [8:0] O_STORE = 9'b000000101;
    localparam logic [8:0] O_PCLD  = 9'b000100000;
    localparam logic [8:0] O_HALT  = 9'b100000000;

    typedef struct {
        logic [15:0] ir;
        bit          force_f;
        logic [2:0]  cnz;
    } instr_t;

    instr_t     prog[$];
    bit         rand_mode = 1'b0;
    bit         cur_force = 1'b0;
    logic [2:0] cur_cnz   = 3'b000;

    // Instruction-level model: running?, halted?, cycle within instruction, latched class/psr.
    bit         m_run   = 1'b0;
    bit         m_halt  = 1'b0;
    bit         m_taken = 1'b0;
    int         m_ph    = 0;
    logic [2:0] m_cls   = 3'b000;
    logic [2:0] m_psr   = 3'b000;

    function automatic logic [8:0] outs();
        return {bus.halted, bus.w_en, bus.s_sel, bus.pc_ld, bus.pc_inc,
                bus.ir_ld, bus.adr_sel, bus.mr_en, bus.mw_en};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Branch rule: odd codes test a flag set, even codes test it clear; 0 always, 7 never.
    function automatic bit taken_of(input logic [2:0] cond, input logic [2:0] psr);
        int  sel;
        bit  flag;
        if (cond == 3'd0) return 1'b1;
        if (cond == 3'd7) return 1'b0;
        sel  = (int'(cond) - 1) / 2;
        flag = (sel == 0) ? psr[0] : (sel == 1) ? psr[2] : psr[1];
        return cond[0] ? flag : !flag;
    endfunction

    function automatic logic [8:0] exp_outs();
        if (!reset || !m_run) return O_NONE;
        if (m_halt)           return O_HALT;
        if (m_ph == 0)        return O_FETCH;
        if (m_ph == 1)        return O_NONE;
        case (m_cls)
            3'd0:    return O_ALU;
            3'd1:    return O_LOAD;
            3'd2:    return O_STORE;
            3'd3:    return O_PCLD;
            3'd4:    return m_taken ? O_PCLD : O_NONE;
            default: return O_NONE;
        endcase
    endfunction

    task automatic model_check_update();
        logic [2:0] cls;
        chk("outs", 16'(outs()), 16'(exp_outs()));
        chk("psr", 16'(bus.psr), reset ? 16'(m_psr) : 16'h0);
        chk("exclusive", 16'({bus.pc_ld & bus.pc_inc, bus.mr_en & bus.mw_en, bus.w_en & bus.mw_en}), 16'h0);
        if (!reset) begin
            m_run  = 1'b0;
            m_halt = 1'b0;
            m_psr  = 3'b000;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_ph  = 0;
        end else if (!m_halt) begin
            case (m_ph)
                0: m_ph = 1;
                1: begin
                    cls = bus.ir[11:9];
                    if (cls == 3'd7) begin
                        m_halt = 1'b1;
                    end else if (cls == 3'd5 || cls == 3'd6) begin
`ifdef CPU_CU_ILLEGAL_TRAP_EN
                        m_halt = 1'b1;
`else
                        m_ph = 0;
`endif
                    end else begin
                        m_cls   = cls;
                        m_taken = taken_of(bus.ir[8:6], m_psr);
                        m_ph    = 2;
                    end
                end
                default: begin
                    if (m_cls == 3'd0) m_psr = {bus.c, bus.n, bus.z};
                    m_ph = 0;
                end
            endcase
        end
    endtask

    // One clock: drive inputs just after the edge, check and advance the model at the falling edge.
    task automatic step(input bit rst_low);
        instr_t it;
        @(posedge clk);
        #1;
        if (reset && m_run && !m_halt && m_ph == 1) begin
            if (prog.size() > 0) begin
                it        = prog.pop_front();
                bus.ir    = it.ir;
                cur_force = it.force_f;
                cur_cnz   = it.cnz;
            end else begin
                bus.ir    = rand_mode ? 16'($urandom) : 16'h0000;
                cur_force = 1'b0;
            end
        end
        if (reset && m_run && !m_halt && m_ph == 2 && cur_force)
            {bus.c, bus.n, bus.z} = cur_cnz;
        else
            {bus.c, bus.n, bus.z} = 3'($urandom);
        if (rst_low && reset) begin
            reset = 1'b0;
            #1;
            chk("rst_async_outs", 16'(outs()), 16'(O_NONE));
            chk("rst_async_psr", 16'(bus.psr), 16'h0);
        end else if (!rst_low) begin
            reset = 1'b1;
        end
        @(negedge clk);
        model_check_update();
    endtask

    initial begin
        bus.ir = 16'h0000;
        bus.c  = 1'b0;
        bus.n  = 1'b0;
        bus.z  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) step(1'b1);
        chk("reset_outs", 16'(outs()), 16'(O_NONE));

        // ALU with flags 1,0,1 then LOAD and STORE
        prog.push_back('{16'h0000, 1'b1, 3'b101});
        prog.push_back('{16'h1200, 1'b0, 3'b000});
        prog.push_back('{16'h0400, 1'b0, 3'b000});
        step(1'b0);
        chk("t1_reset_cycle", 16'(outs()), 16'(O_NONE));
        step(1'b0); chk("t1_fetch",  16'(outs()), 16'(O_FETCH));
        step(1'b0); chk("t1_decode", 16'(outs()), 16'(O_NONE));
        step(1'b0); chk("t1_exec",   16'(outs()), 16'(O_ALU));
        step(1'b0); chk("t2_psr",    16'(bus.psr), 16'h5);
        step(1'b0); step(1'b0);
        chk("t3_load", 16'(outs()), 16'(O_LOAD));
        step(1'b0); chk("t2_psr_kept", 16'(bus.psr), 16'h5);
        step(1'b0); step(1'b0);
        chk("t3_store", 16'(outs()), 16'(O_STORE));

        // Z=1 then branches on Z, !Z, never
        prog.push_back('{16'h0000, 1'b1, 3'b001});
        prog.push_back('{16'h0840, 1'b0, 3'b000});
        prog.push_back('{16'h0880, 1'b0, 3'b000});
        prog.push_back('{16'h09C0, 1'b0, 3'b000});
        repeat (3) step(1'b0);
        step(1'b0); chk("t4_psr_z", 16'(bus.psr), 16'h1);
        step(1'b0); step(1'b0);
        chk("t4_bz_taken", 16'(outs()), 16'(O_PCLD));
        repeat (3) step(1'b0);
        chk("t4_bnz_not", 16'(outs()), 16'(O_NONE));
        repeat (3) step(1'b0);
        chk("t4_never", 16'(outs()), 16'(O_NONE));

        // HALT holds for 10 cycles, reset pulse restarts
        prog.push_back('{16'h0E00, 1'b0, 3'b000});
        repeat (3) step(1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("t5_halted", 16'(outs()), 16'(O_HALT));
            step(1'b0);
        end
        step(1'b1);
        step(1'b0); chk("t5_reset_state", 16'(outs()), 16'(O_NONE));
        step(1'b0); chk("t5_fetch",       16'(outs()), 16'(O_FETCH));

        // Reset during DECODE of a STORE, then illegal class 101
        prog.push_back('{16'h0400, 1'b0, 3'b000});
        step(1'b1);
        step(1'b1);
        chk("t6_no_store", 16'(outs()), 16'(O_NONE));
        prog.delete();
        prog.push_back('{16'h0A00, 1'b0, 3'b000});
        step(1'b0);
        step(1'b0); chk("t6_fetch",  16'(outs()), 16'(O_FETCH));
        step(1'b0); chk("t6_decode", 16'(outs()), 16'(O_NONE));
        step(1'b0);
`ifdef CPU_CU_ILLEGAL_TRAP_EN
        chk("t6_illegal", 16'(outs()), 16'(O_HALT));
`else
        chk("t6_illegal", 16'(outs()), 16'(O_FETCH));
`endif
        step(1'b1);

        // Random instruction streams with occasional resets
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
